// File: rtl/down_counter_zero.sv
// Loadable countdown timer with a prescaler and one-shot or auto-reload modes.
// The count feeds an 8-bit zero detector; done pulses on the tick that reaches zero.
module down_counter_zero #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             auto,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             done,
    output logic             busy
);

    localparam int unsigned PW = (DIV <= 1) ? 1 : $clog2(DIV);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             done_q, done_d;
    logic             tick;

    assign tick = (presc_q == PW'(DIV - 1));

    // Priority: load, then stop, then counting in RUN with en.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        done_d   = 1'b0;
        if (load) begin
            count_d  = d;
            reload_d = d;
            presc_d  = '0;
            state_d  = (d != '0) ? RUN : IDLE;
        end else if (stop) begin
            state_d = IDLE;
            presc_d = '0;
        end else if (state_q == RUN && en) begin
            if (!tick) begin
                presc_d = presc_q + 1'b1;
            end else begin
                presc_d = '0;
                if (count_q > WIDTH'(1)) begin
                    count_d = count_q - 1'b1;
                end else if (count_q == WIDTH'(1)) begin
                    count_d = '0;
                    done_d  = 1'b1;
                    if (!auto) state_d = IDLE;
                end else begin
                    // Zero held for one tick period in auto mode, then reload.
                    count_d = reload_q;
                    if (reload_q == '0) state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
        end
    end

    assign q    = count_q;
    assign zero = (count_q == '0);
    assign done = done_q;
    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_zero.sv
// Directed bench for down_counter_zero: one instance with DIV=1, one with DIV=4,
// sharing stimulus; each scenario checks the instance it targets.
module tb_down_counter_zero;

    logic       clk, rst_n, load, en, auto, stop;
    logic [7:0] d;
    logic [7:0] q1, q4;
    logic       zero1, done1, busy1, zero4, done4, busy4;

    int n_cmp = 0;
    int n_err = 0;

    down_counter_zero #(.WIDTH(8), .DIV(1)) u_dut_div1 (
        .clk(clk), .rst_n(rst_n), .load(load), .d(d), .en(en), .auto(auto), .stop(stop),
        .q(q1), .zero(zero1), .done(done1), .busy(busy1)
    );

    down_counter_zero #(.WIDTH(8), .DIV(4)) u_dut_div4 (
        .clk(clk), .rst_n(rst_n), .load(load), .d(d), .en(en), .auto(auto), .stop(stop),
        .q(q4), .zero(zero4), .done(done4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_done;
        logic [7:0] auto_q[6];
        logic       auto_done[6];
        auto_q    = '{8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2};
        auto_done = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; load = 1'b0; en = 1'b0; auto = 1'b0; stop = 1'b0; d = 8'd0;
        #2;
        check("rst_q", q1, 0);
        check("rst_zero", zero1, 1);
        check("rst_done", done1, 0);
        check("rst_busy", busy1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot, DIV=1, load 3
        load = 1'b1; d = 8'd3; en = 1'b1; auto = 1'b0;
        step();
        load = 1'b0;
        check("os_q3", q1, 3);
        check("os_busy", busy1, 1);
        check("os_done_at_load", done1, 0);
        step(); check("os_q2", q1, 2);
        step(); check("os_q1", q1, 1); check("os_done_early", done1, 0);
        step(); check("os_q0", q1, 0); check("os_done", done1, 1); check("os_zero", zero1, 1);
        check("os_idle", busy1, 0);
        step(); check("os_hold", q1, 0); check("os_done_once", done1, 0);
        check("os_idle2", busy1, 0);

        // Prescale, DIV=4, load 2: q changes every 4 cycles, done 8 cycles after load
        load = 1'b1; d = 8'd2;
        step();
        load = 1'b0;
        check("ps_q_load", q4, 2);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("ps_q_%0d", k), q4, (k < 4) ? 2 : (k < 8) ? 1 : 0);
            check($sformatf("ps_done_%0d", k), done4, (k == 8) ? 1 : 0);
        end

        // Auto-reload, DIV=1, load 2: 2,1,0,2,1,0...
        load = 1'b1; d = 8'd2; auto = 1'b1;
        step();
        load = 1'b0;
        check("ar_q_load", q1, 2);
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("ar_q_%0d", k), q1, auto_q[k]);
            check($sformatf("ar_done_%0d", k), done1, auto_done[k]);
            check($sformatf("ar_busy_%0d", k), busy1, 1);
        end
        auto = 1'b0;

        // Pause then stop
        load = 1'b1; d = 8'd5;
        step();
        load = 1'b0;
        step(); step();
        check("pz_q3", q1, 3);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("pz_hold_%0d", k), q1, 3);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_busy", busy1, 0);
        check("stop_q", q1, 3);
        check("stop_done", done1, 0);
        en = 1'b1;
        step();
        check("stop_q_idle", q1, 3);

        // Load zero
        load = 1'b1; d = 8'd0;
        step();
        load = 1'b0;
        check("lz_busy", busy1, 0);
        check("lz_zero", zero1, 1);
        check("lz_done", done1, 0);
        step();
        check("lz_done2", done1, 0);

        // Load 0xFF: done exactly 255 cycles later
        load = 1'b1; d = 8'hFF;
        step();
        load = 1'b0;
        check("ff_q", q1, 8'hFF);
        first_done = -1;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (done1 && first_done < 0) first_done = k;
            if (first_done >= 0) break;
        end
        check("ff_done_cycle", first_done, 255);
        check("ff_q0", q1, 0);

        // Load collides with the expiring tick
        load = 1'b1; d = 8'd2;
        step();
        load = 1'b0;
        step();
        check("col_q1", q1, 1);
        load = 1'b1; d = 8'd7;
        step();
        load = 1'b0;
        check("col_q7", q1, 7);
        check("col_done", done1, 0);
        check("col_busy", busy1, 1);

        // Asynchronous reset between edges
        load = 1'b1; d = 8'd10;
        step();
        load = 1'b0;
        check("ar_pre_q", q1, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_q", q1, 0);
        check("async_busy", busy1, 0);
        check("async_done", done1, 0);
        check("async_zero", zero1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/down_counter_zero.md
Name: down_counter_zero

Overview:
- Loadable 8-bit countdown timer with prescaler, one-shot and auto-reload modes.
- Q is the operand presented directly to the downstream 8-bit zero detector.
- DONE is a single-cycle pulse when the count reaches zero.
- Serves as the upstream timing/loop-count stage for the zero-detect path; a control FSM waits on DONE or ZERO.

Parameters:
- WIDTH, 8, counter width. Must be 8 to match the downstream zero detector.
- DIV, 1, prescale divisor, legal range 1..256. One count tick occurs every DIV enabled cycles.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- LOAD  input  1  synchronous load of D into Q and the reload register
- D  input  8  load value
- EN  input  1  count enable; when 0, the counter pauses and holds state
- AUTO  input  1  0 = one-shot, 1 = auto-reload
- STOP  input  1  synchronous abort to IDLE
- Q  output  8  current count, registered
- ZERO  output  1  combinational (Q == 8'h00)
- DONE  output  1  registered one-cycle pulse
- BUSY  output  1  high in RUN state

Behaviour:
- Reset (RST_N = 0, asynchronous, takes effect immediately, including mid-count):
  - Q = 0, RELOAD = 0, prescaler = 0, DONE = 0, state = IDLE.
  - Therefore BUSY = 0 and ZERO = 1.
- State machine: IDLE, RUN. BUSY = (state == RUN).
- Priority per rising edge: LOAD > STOP > count.
- DONE defaults to 0 every cycle unless set by the tick rule below.
- LOAD = 1:
  - Q <= D, RELOAD <= D, prescaler <= 0, DONE <= 0.
  - state <= RUN if D != 0, else IDLE.
  - Loading 0 never produces DONE.
- STOP = 1 (with LOAD = 0):
  - state <= IDLE, prescaler <= 0.
  - Q and RELOAD hold; DONE <= 0.
- IDLE: Q, RELOAD and prescaler hold; EN and AUTO are ignored.
- RUN with EN = 0: Q, prescaler and state hold.
- RUN with EN = 1:
  - tick = (prescaler == DIV-1).
  - On no tick: prescaler <= prescaler + 1.
  - On tick: prescaler <= 0, then:
    - Q > 1: Q <= Q - 1.
    - Q == 1: Q <= 0 and DONE <= 1 on the same edge. If AUTO = 0, state <= IDLE; if AUTO = 1, state stays RUN.
    - Q == 0 (reachable only in auto mode): Q <= RELOAD, no DONE. If RELOAD == 0, state <= IDLE.
- Period: one-shot expires after N ticks for load value N. Auto-reload period is (RELOAD + 1) ticks, with Q visible at 0 for exactly one tick period.
- AUTO is sampled at the tick where Q == 1. Changing AUTO mid-count has no other effect.
- Arithmetic: unsigned 8-bit decrement. Q never wraps below 0 (0 -> 8'hFF never occurs).
- Prescaler width is max(1, ceil(log2 DIV)). With DIV = 1 every enabled RUN cycle is a tick.
- Simultaneous events:
  - LOAD on a tick edge: load wins, DONE = 0, prescaler restarts at 0.
  - STOP on a tick edge: stop wins, Q not decremented.
- ZERO is purely combinational from Q with no added latency. DONE coincides with the first cycle of ZERO = 1 after expiry.

Test Plan:
- Reset, DIV=1: hold RST_N=0 -> Q=0, ZERO=1, DONE=0, BUSY=0. Release RST_N, pulse LOAD with D=3, AUTO=0, EN=1 -> Q=3,2,1,0 on successive edges. DONE=1 exactly on the edge Q becomes 0. BUSY then drops to 0 and Q holds 0.
- Prescale, DIV=4: LOAD D=2, EN=1 -> Q changes every 4 cycles: 2 (4 cycles), 1 (4 cycles), 0 plus DONE. DONE is exactly 8 cycles after load.
- Auto-reload, DIV=1: LOAD D=2, AUTO=1 -> Q=2,1,0,2,1,0,... DONE pulses every 3 cycles; BUSY stays 1.
- Pause/stop: LOAD D=5, EN=1 for 2 cycles (Q=3), EN=0 for 5 cycles -> Q holds 3. STOP=1 -> BUSY=0, Q=3 held, no DONE.
- Corner loads:
  - LOAD D=0 -> BUSY=0, ZERO=1, no DONE.
  - LOAD D=8'hFF with DIV=1 -> DONE after exactly 255 cycles.
  - LOAD D=7 asserted on the edge where Q==1 ticks -> Q=7, DONE=0.
- Async reset mid-run: LOAD D=10, then drive RST_N low between clock edges -> Q=0, BUSY=0, DONE=0 immediately, without waiting for a clock edge.
